// File: rtl/ones_density_mon_if.sv
// Event port of the ones-density monitor: timestamped alarm transitions
// handed to control/CSR logic over a single-entry valid/ready register.
interface ones_density_mon_if #(
    parameter int TS_W = 16
);
    logic            evt_valid;
    logic            evt_ready;
    logic            evt_type;
    logic [TS_W-1:0] evt_ts;
    logic            evt_ovf;

    modport master (
        output evt_valid,
        output evt_type,
        output evt_ts,
        output evt_ovf,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_type,
        input  evt_ts,
        input  evt_ovf,
        output evt_ready
    );
endinterface

// File: rtl/ones_density_mon.sv
// Monitors per-cycle popcount totals: interval min/max, a dwell-debounced
// hysteresis alarm, and timestamped alarm assert/release events.
module ones_density_mon #(
    parameter int WORD_SIZE = 256,
    parameter int BIT_RES   = $clog2(WORD_SIZE * 8),
    parameter int DWELL_W   = 8,
    parameter int TS_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BIT_RES-1:0] ones,
    input  logic               en,
    input  logic [BIT_RES-1:0] hi_thr,
    input  logic [BIT_RES-1:0] lo_thr,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               stat_clr,
    output logic               alarm,
    output logic [BIT_RES-1:0] max_ones,
    output logic [BIT_RES-1:0] min_ones,
    ones_density_mon_if.master evt
);

    typedef enum logic [1:0] {
        NORMAL,
        ARMING,
        ALARM,
        CLEARING
    } state_t;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [TS_W-1:0]    ts_q;
    logic               hi, lo;
    logic               fire, fire_type;
    logic               load, drop, accept;

    assign hi = en & (ones > hi_thr);
    assign lo = en & (ones < lo_thr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fire      = 1'b0;
        fire_type = 1'b0;
        case (state_q)
            NORMAL: begin
                if (hi) begin
                    if (dwell == '0) begin
                        state_d   = ALARM;
                        fire      = 1'b1;
                        fire_type = 1'b1;
                    end else begin
                        state_d = ARMING;
                        cnt_d   = DWELL_W'(1);
                    end
                end
            end
            ARMING: begin
                if (hi) begin
                    if (cnt_q == dwell) begin
                        state_d   = ALARM;
                        fire      = 1'b1;
                        fire_type = 1'b1;
                    end else begin
                        cnt_d = cnt_q + DWELL_W'(1);
                    end
                end else if (en) begin
                    state_d = NORMAL;
                end
            end
            ALARM: begin
                if (lo) begin
                    if (dwell == '0) begin
                        state_d = NORMAL;
                        fire    = 1'b1;
                    end else begin
                        state_d = CLEARING;
                        cnt_d   = DWELL_W'(1);
                    end
                end
            end
            CLEARING: begin
                if (lo) begin
                    if (cnt_q == dwell) begin
                        state_d = NORMAL;
                        fire    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + DWELL_W'(1);
                    end
                end else if (en) begin
                    state_d = ALARM;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    assign alarm = (state_q == ALARM) || (state_q == CLEARING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + TS_W'(1);
    end

    // A slot being drained this cycle may be refilled; otherwise a new event is lost.
    assign accept = evt.evt_valid & evt.evt_ready;
    assign load   = fire & (~evt.evt_valid | evt.evt_ready);
    assign drop   = fire & ~load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt.evt_valid <= 1'b0;
            evt.evt_type  <= 1'b0;
            evt.evt_ts    <= '0;
            evt.evt_ovf   <= 1'b0;
        end else begin
            if (load) begin
                evt.evt_valid <= 1'b1;
                evt.evt_type  <= fire_type;
                evt.evt_ts    <= ts_q;
            end else if (accept) begin
                evt.evt_valid <= 1'b0;
            end
            if (drop)          evt.evt_ovf <= 1'b1;
            else if (stat_clr) evt.evt_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_ones <= '0;
            min_ones <= '1;
        end else if (stat_clr) begin
            max_ones <= en ? ones : '0;
            min_ones <= en ? ones : '1;
        end else if (en) begin
            if (ones > max_ones) max_ones <= ones;
            if (ones < min_ones) min_ones <= ones;
        end
    end

endmodule

// File: tb/tb_ones_density_mon.sv
// Directed bench for ones_density_mon: alarm hysteresis, event handshake,
// overflow, min/max intervals, timestamp wrap and asynchronous reset.
module tb_ones_density_mon;

    localparam int BIT_RES = 11;
    localparam int DWELL_W = 8;
    localparam int TS_W    = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [BIT_RES-1:0] ones;
    logic               en;
    logic [BIT_RES-1:0] hi_thr;
    logic [BIT_RES-1:0] lo_thr;
    logic [DWELL_W-1:0] dwell;
    logic               stat_clr;
    logic               alarm;
    logic [BIT_RES-1:0] max_ones;
    logic [BIT_RES-1:0] min_ones;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    ones_density_mon_if #(.TS_W(TS_W)) evt_if ();

    ones_density_mon #(
        .WORD_SIZE(256),
        .DWELL_W  (DWELL_W),
        .TS_W     (TS_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ones    (ones),
        .en      (en),
        .hi_thr  (hi_thr),
        .lo_thr  (lo_thr),
        .dwell   (dwell),
        .stat_clr(stat_clr),
        .alarm   (alarm),
        .max_ones(max_ones),
        .min_ones(min_ones),
        .evt     (evt_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned o, input logic e);
        ones = BIT_RES'(o);
        en   = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n            = 1'b0;
        ones             = '0;
        en               = 1'b0;
        hi_thr           = 11'd100;
        lo_thr           = 11'd50;
        dwell            = 8'd2;
        stat_clr         = 1'b0;
        evt_if.evt_ready = 1'b0;
        #23;
        chk("rst_alarm", 32'(alarm), 0);
        chk("rst_valid", 32'(evt_if.evt_valid), 0);
        chk("rst_type", 32'(evt_if.evt_type), 0);
        chk("rst_ts", 32'(evt_if.evt_ts), 0);
        chk("rst_ovf", 32'(evt_if.evt_ovf), 0);
        chk("rst_max", 32'(max_ones), 0);
        chk("rst_min", 32'(min_ones), 2047);
        @(negedge clk);
        rst_n = 1'b1;

        // Assert after three consecutive hi samples at dwell 2 (ts 0..2)
        step(120, 1);
        chk("arm1_alarm", 32'(alarm), 0);
        step(120, 1);
        chk("arm2_alarm", 32'(alarm), 0);
        chk("arm2_valid", 32'(evt_if.evt_valid), 0);
        step(120, 1);
        chk("asrt_alarm", 32'(alarm), 1);
        chk("asrt_valid", 32'(evt_if.evt_valid), 1);
        chk("asrt_type", 32'(evt_if.evt_type), 1);
        chk("asrt_ts", 32'(evt_if.evt_ts), 2);
        chk("asrt_max", 32'(max_ones), 120);
        chk("asrt_min", 32'(min_ones), 120);
        evt_if.evt_ready = 1'b1;
        step(0, 0);
        chk("acc1_valid", 32'(evt_if.evt_valid), 0);

        // Release: 40,60 (abort),40,40,40 at ts 4..8
        evt_if.evt_ready = 1'b0;
        step(40, 1);
        step(60, 1);
        chk("abort_alarm", 32'(alarm), 1);
        step(40, 1);
        step(40, 1);
        chk("clr2_alarm", 32'(alarm), 1);
        chk("clr2_valid", 32'(evt_if.evt_valid), 0);
        step(40, 1);
        chk("rel_alarm", 32'(alarm), 0);
        chk("rel_valid", 32'(evt_if.evt_valid), 1);
        chk("rel_type", 32'(evt_if.evt_type), 0);
        chk("rel_ts", 32'(evt_if.evt_ts), 8);
        chk("rel_min", 32'(min_ones), 40);
        evt_if.evt_ready = 1'b1;
        step(0, 0);
        chk("acc2_valid", 32'(evt_if.evt_valid), 0);

        // Overflow: dwell 0, toggling 120/40 at ts 10..13 with no acceptance
        evt_if.evt_ready = 1'b0;
        dwell            = 8'd0;
        step(120, 1);
        step(40, 1);
        step(120, 1);
        step(40, 1);
        chk("ovf_valid", 32'(evt_if.evt_valid), 1);
        chk("ovf_type", 32'(evt_if.evt_type), 1);
        chk("ovf_ts", 32'(evt_if.evt_ts), 10);
        chk("ovf_flag", 32'(evt_if.evt_ovf), 1);
        chk("ovf_alarm", 32'(alarm), 0);
        stat_clr = 1'b1;
        step(0, 0);
        stat_clr = 1'b0;
        chk("sclr_ovf", 32'(evt_if.evt_ovf), 0);
        chk("sclr_valid", 32'(evt_if.evt_valid), 1);
        chk("sclr_ts", 32'(evt_if.evt_ts), 10);
        chk("sclr_max", 32'(max_ones), 0);
        chk("sclr_min", 32'(min_ones), 2047);
        evt_if.evt_ready = 1'b1;
        step(0, 0);
        chk("acc3_valid", 32'(evt_if.evt_valid), 0);

        // Disabled cycle inside a dwell run (ts 16..19)
        evt_if.evt_ready = 1'b0;
        dwell            = 8'd2;
        step(120, 1);
        step(0, 0);
        step(120, 1);
        chk("gap_alarm", 32'(alarm), 0);
        step(120, 1);
        chk("gap_asrt_alarm", 32'(alarm), 1);
        chk("gap_asrt_ts", 32'(evt_if.evt_ts), 19);
        chk("gap_min", 32'(min_ones), 120);
        chk("gap_max", 32'(max_ones), 120);
        evt_if.evt_ready = 1'b1;
        step(0, 0);
        chk("acc4_valid", 32'(evt_if.evt_valid), 0);

        // Min/max interval then stat_clr with a live sample
        step(30, 1);
        step(200, 1);
        step(90, 1);
        chk("mm_min", 32'(min_ones), 30);
        chk("mm_max", 32'(max_ones), 200);
        chk("mm_alarm", 32'(alarm), 1);
        stat_clr = 1'b1;
        step(77, 1);
        stat_clr = 1'b0;
        chk("mmclr_min", 32'(min_ones), 77);
        chk("mmclr_max", 32'(max_ones), 77);

        // stat_clr coinciding with a dropped event (ts 25, 26)
        evt_if.evt_ready = 1'b0;
        dwell            = 8'd0;
        step(40, 1);
        stat_clr = 1'b1;
        step(120, 1);
        stat_clr = 1'b0;
        chk("setwin_ovf", 32'(evt_if.evt_ovf), 1);
        chk("setwin_valid", 32'(evt_if.evt_valid), 1);
        chk("setwin_type", 32'(evt_if.evt_type), 0);
        chk("setwin_ts", 32'(evt_if.evt_ts), 25);
        chk("setwin_max", 32'(max_ones), 120);
        chk("setwin_min", 32'(min_ones), 120);

        // Timestamp wrap: accept at ts 27, idle to ts 3 of the next lap
        evt_if.evt_ready = 1'b1;
        step(0, 0);
        for (int i = 0; i < 65511; i++) step(0, 0);
        evt_if.evt_ready = 1'b0;
        step(40, 1);
        chk("wrap_valid", 32'(evt_if.evt_valid), 1);
        chk("wrap_type", 32'(evt_if.evt_type), 0);
        chk("wrap_ts", 32'(evt_if.evt_ts), 3);
        step(120, 1);
        dwell = 8'd2;
        step(40, 1);
        chk("pre_rst_alarm", 32'(alarm), 1);
        chk("pre_rst_valid", 32'(evt_if.evt_valid), 1);
        chk("pre_rst_ovf", 32'(evt_if.evt_ovf), 1);

        // Asynchronous reset mid-dwell with an event pending
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_alarm", 32'(alarm), 0);
        chk("arst_valid", 32'(evt_if.evt_valid), 0);
        chk("arst_ts", 32'(evt_if.evt_ts), 0);
        chk("arst_ovf", 32'(evt_if.evt_ovf), 0);
        chk("arst_max", 32'(max_ones), 0);
        chk("arst_min", 32'(min_ones), 2047);
        @(negedge clk);
        rst_n            = 1'b1;
        evt_if.evt_ready = 1'b1;
        step(120, 1);
        step(120, 1);
        chk("post_rst_alarm", 32'(alarm), 0);
        step(120, 1);
        chk("post_rst_asrt", 32'(alarm), 1);
        chk("post_rst_ts", 32'(evt_if.evt_ts), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ones_density_mon.md
# ones_density_mon

Downstream monitor for the serial popcount stage. Consumes the per-cycle `ones` total, tracks min/max over a statistics interval, and raises a debounced hysteresis alarm when bit density crosses programmable thresholds. Each alarm assert and deassert is reported as a timestamped event on a valid/ready port toward the control/CSR logic.

## Interface
- `WORD_SIZE`, 256: window size in bits of the upstream popcount; sets `BIT_RES`.
- `BIT_RES`, $clog2(WORD_SIZE*8): width of `ones`, the thresholds and the min/max outputs.
- `DWELL_W`, 8: width of the `dwell` config.
- `TS_W`, 16: width of the timestamp counter.

- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ones` in BIT_RES: popcount sample, one per cycle.
- `en` in 1: sample qualifier; `ones` is ignored when 0.
- `hi_thr` in BIT_RES: assert threshold, strict compare `ones > hi_thr`.
- `lo_thr` in BIT_RES: release threshold, strict compare `ones < lo_thr`.
- `dwell` in DWELL_W: the condition must hold for `dwell`+1 consecutive enabled samples.
- `stat_clr` in 1: one-cycle pulse that starts a new statistics interval.
- `alarm` out 1: debounced alarm level.
- `max_ones` out BIT_RES: maximum enabled sample in the current interval.
- `min_ones` out BIT_RES: minimum enabled sample in the current interval.
- `evt_valid` out 1: event available.
- `evt_ready` in 1: consumer accepts the event.
- `evt_type` out 1: 1 = alarm asserted, 0 = alarm released.
- `evt_ts` out TS_W: timestamp of the sample that completed the transition.
- `evt_ovf` out 1: sticky flag, set when an event was dropped.

## Operation
- FSM states: NORMAL, ARMING, ALARM, CLEARING, with a dwell counter `cnt` (DWELL_W bits).
- A "hi" sample is `en & (ones > hi_thr)`. A "lo" sample is `en & (ones < lo_thr)`.
- NORMAL:
  - hi sample with `dwell`==0 -> ALARM, emit assert event.
  - hi sample with `dwell`!=0 -> ARMING, `cnt`=1.
- ARMING:
  - hi sample with `cnt`==`dwell` -> ALARM, emit assert event.
  - hi sample otherwise -> `cnt`++.
  - enabled non-hi sample -> NORMAL.
- ALARM and CLEARING mirror NORMAL and ARMING, using lo samples. Completing the dwell goes CLEARING -> NORMAL and emits a release event. An enabled non-lo sample in CLEARING returns to ALARM.
- `en`=0: FSM and `cnt` hold. Disabled cycles do not break the consecutive run.
- Config inputs are used live every cycle. `hi_thr` < `lo_thr` is legal and the rules above apply literally.
- `alarm` = 1 in ALARM or CLEARING, registered from the state.
- Timestamp: a free-running TS_W counter, 0 at reset, +1 every cycle, wraps to 0. An event carries the counter value of the cycle in which the completing sample was presented.
- Event register (single entry):
  - An event loads when the register is empty or is being accepted in the same cycle (`evt_valid & evt_ready`).
  - Otherwise the new event is dropped and `evt_ovf` is set. The pending event is kept unchanged.
  - `evt_type` and `evt_ts` stay stable while `evt_valid`=1. `evt_valid` drops the cycle after acceptance unless a new event loads.
- Min/max:
  - On an enabled sample, `max_ones` = max(`max_ones`, `ones`) and `min_ones` = min(`min_ones`, `ones`).
  - `stat_clr` sets `max_ones`=0, `min_ones`=all-ones and clears `evt_ovf`.
  - `stat_clr` together with `en`: the sample starts the new interval, so both min and max load `ones`.
  - `stat_clr` together with a drop: `evt_ovf` ends at 1 (set wins).
  - `stat_clr` does not affect the FSM, the timestamp or a pending event.

## Timing
- Reset values: `alarm`=0, `evt_valid`=0, `evt_type`=0, `evt_ts`=0, `evt_ovf`=0, `max_ones`=0, `min_ones`=all-ones. FSM in NORMAL, `cnt`=0, timestamp=0.
- Reset asserted mid-operation returns all outputs to these values immediately, whether an event is pending or the FSM is mid-dwell. The pending event is lost.
- The completing sample in cycle n gives `alarm` and `evt_valid` high from cycle n+1.
- Min/max reflect the cycle-n sample from cycle n+1.
- Minimum spacing between two events is `dwell`+1 cycles. With `evt_ready` held high, no drops occur for `dwell`>=1.

## Test plan
- Reset, then `en`=1, `hi_thr`=100, `lo_thr`=50, `dwell`=2, samples 120,120,120 in cycles 0-2 -> `alarm`=1 and `evt_valid`=1 from cycle 3, `evt_type`=1, `evt_ts`=2.
- In ALARM, samples 40,60,40,40,40 -> the 60 aborts CLEARING; release event after the third consecutive 40, `alarm`=0 the next cycle.
- Hold `evt_ready`=0 with `dwell`=0 and samples toggling 120/40 -> first event retained with its original `evt_ts`, `evt_ovf`=1. Then `stat_clr` -> `evt_ovf`=0 and the pending event is still valid.
- Samples 120,(`en`=0 with 0),120,120 at `dwell`=2 -> alarm asserts; the disabled cycle neither breaks the run nor updates min/max.
- Samples 30,200,90 then `stat_clr` with `en` and `ones`=77 -> min/max were 30/200 before the clear, and both are 77 after.
- Run 65536+ cycles, then trigger an event -> `evt_ts` wraps correctly. Assert `rst_n` while `evt_valid`=1 -> all outputs return to reset values.
